// File: rtl/input_debounce.sv
// ----------------------------------------------------------------------------
// input_debounce
//   Button front end: synchronises the eight raw K0/K1 pin levels into the
//   clk domain and debounces each lane independently. A lane's output only
//   adopts a new level after DEBOUNCE_CYCLES uninterrupted differing samples.
//
//   Optional feature (macro INPUT_DEBOUNCE_CHANGE_STROBE_EN):
//     adds change_strobe[7:0], a one-cycle pulse coincident with each output
//     bit update (bits [3:0] = k0, bits [7:4] = k1).
//
//   Reset: reset_n asserts asynchronously everywhere. The pin synchronisers
//   release directly with reset_n; the debounce counters and outputs release
//   through a two-flop reset synchroniser. By the time the first synchronised
//   pin sample reaches s2 the debounce logic is out of reset, so the latency
//   from release matches the latency from a clean input change (2 + D edges).
// ----------------------------------------------------------------------------
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4096,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] raw_k0,
    input  logic [3:0] raw_k1,
    output logic [3:0] input_k0,
    output logic [3:0] input_k1
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
    ,
    output logic [7:0] change_strobe
`endif
);

    localparam int unsigned      LANES    = 8;
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       IDLE_VEC = {8{IDLE_LEVEL}};

    // Lane order: bits [3:0] are K00..K03, bits [7:4] are K10..K13
    logic [7:0] raw_s;
    logic [7:0] sync1_r;
    logic [7:0] sync2_r;
    logic [7:0] level_r;
    logic [1:0] rst_sync_r;
    logic       core_rst_n_s;

`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
    logic [7:0] strobe_r;
`endif

    assign raw_s        = {raw_k1, raw_k0};
    assign core_rst_n_s = rst_sync_r[1];

    // Reset release synchroniser: asserts with reset_n, releases two clk edges later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Two-flop pin synchroniser for all eight lanes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= IDLE_VEC;
            sync2_r <= IDLE_VEC;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        logic [CNT_W-1:0] count_r;

        // Debounce counter and output level for one lane; counter never wraps
        always_ff @(posedge clk or negedge core_rst_n_s) begin
            if (!core_rst_n_s) begin
                count_r        <= '0;
                level_r[lane]  <= IDLE_LEVEL;
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
                strobe_r[lane] <= 1'b0;
`endif
            end else if (sync2_r[lane] == level_r[lane]) begin
                count_r        <= '0;
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
                strobe_r[lane] <= 1'b0;
`endif
            end else if (count_r != CNT_LAST) begin
                count_r        <= count_r + CNT_ONE;
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
                strobe_r[lane] <= 1'b0;
`endif
            end else begin
                count_r        <= '0;
                level_r[lane]  <= sync2_r[lane];
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
                strobe_r[lane] <= 1'b1;
`endif
            end
        end
    end

    assign input_k0 = level_r[3:0];
    assign input_k1 = level_r[7:4];

`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
    assign change_strobe = strobe_r;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// ----------------------------------------------------------------------------
// tb_input_debounce
//   Three instances (DEBOUNCE_CYCLES = 4, 8, 1) share the same raw pins and
//   reset. Each clk edge the reference model computes the expected output
//   levels (and strobes when INPUT_DEBOUNCE_CHANGE_STROBE_EN is defined) and
//   pushes them into a queue; a monitor on the falling edge pops and compares.
//   The model decides a lane change from a sliding window of synchronised
//   samples: the level flips when the last D samples all differ from it.
// ----------------------------------------------------------------------------
module tb_input_debounce;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [2:0][7:0] lvl;
        logic [2:0][7:0] stb;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] raw;

    logic [3:0] k0 [NDUT];
    logic [3:0] k1 [NDUT];
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
    logic [7:0] stb [NDUT];
`endif

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // reference model state
    int         dval   [NDUT] = '{4, 8, 1};
    logic [7:0] m_s1   [NDUT];
    logic [7:0] m_s2   [NDUT];
    logic [7:0] m_lvl  [NDUT];
    logic [7:0] m_stb  [NDUT];
    logic [7:0] m_hist [NDUT][8];
    int         m_hlen [NDUT];
    int         m_rel  [NDUT];

    input_debounce #(.DEBOUNCE_CYCLES(4), .IDLE_LEVEL(1'b1)) u_d4 (
        .clk(clk), .reset_n(reset_n), .raw_k0(raw[3:0]), .raw_k1(raw[7:4]),
        .input_k0(k0[0]), .input_k1(k1[0])
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
        , .change_strobe(stb[0])
`endif
    );

    input_debounce #(.DEBOUNCE_CYCLES(8), .IDLE_LEVEL(1'b1)) u_d8 (
        .clk(clk), .reset_n(reset_n), .raw_k0(raw[3:0]), .raw_k1(raw[7:4]),
        .input_k0(k0[1]), .input_k1(k1[1])
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
        , .change_strobe(stb[1])
`endif
    );

    input_debounce #(.DEBOUNCE_CYCLES(1), .IDLE_LEVEL(1'b1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .raw_k0(raw[3:0]), .raw_k1(raw[7:4]),
        .input_k0(k0[2]), .input_k1(k1[2])
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
        , .change_strobe(stb[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_idle();
        for (int d = 0; d < NDUT; d++) begin
            m_s1[d]   = 8'hFF;
            m_s2[d]   = 8'hFF;
            m_lvl[d]  = 8'hFF;
            m_stb[d]  = 8'h00;
            m_hlen[d] = 0;
            m_rel[d]  = 0;
        end
    endtask

    // one rising edge of the reference model, using the inputs currently applied
    task automatic model_edge();
        exp_t       e;
        logic [7:0] smp;
        logic [7:0] flips;
        logic       all_diff;
        if (!reset_n) begin
            model_idle();
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                smp      = m_s2[d];
                m_stb[d] = 8'h00;
                if (m_rel[d] < 2) begin
                    m_hlen[d] = 0;
                end else begin
                    for (int k = 7; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                    m_hist[d][0] = smp;
                    if (m_hlen[d] < 8) m_hlen[d]++;
                    flips = 8'h00;
                    if (m_hlen[d] >= dval[d]) begin
                        for (int i = 0; i < 8; i++) begin
                            all_diff = 1'b1;
                            for (int k = 0; k < dval[d]; k++)
                                if (m_hist[d][k][i] == m_lvl[d][i]) all_diff = 1'b0;
                            flips[i] = all_diff;
                        end
                    end
                    m_lvl[d] = m_lvl[d] ^ flips;
                    m_stb[d] = flips;
                end
                m_s2[d] = m_s1[d];
                m_s1[d] = raw;
                if (m_rel[d] < 2) m_rel[d]++;
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            e.lvl[d] = m_lvl[d];
            e.stb[d] = m_stb[d];
        end
        exp_q.push_back(e);
    endtask

    // one clock: model the rising edge, return just after the falling edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        raw = v;
        repeat (n) cycle();
    endtask

    // monitor: compare DUT outputs against the queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    chk($sformatf("level_d%0d", dval[d]), {k1[d], k0[d]}, e.lvl[d]);
`ifdef INPUT_DEBOUNCE_CHANGE_STROBE_EN
                    chk($sformatf("strobe_d%0d", dval[d]), stb[d], e.stb[d]);
`endif
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        raw     = 8'hFF;
        model_idle();
        #1;
        reset_n = 1'b0;
        raw     = 8'h00;

        // reset held with raw low: everything idle high
        repeat (4) cycle();
        for (int d = 0; d < NDUT; d++)
            chk($sformatf("reset_idle_d%0d", dval[d]), {k1[d], k0[d]}, 8'hFF);

        // release with raw low: D=4 falls at edge 6 after release
        reset_n = 1'b1;
        repeat (5) cycle();
        chk("release_edge5_d4", {k1[0], k0[0]}, 8'hFF);
        cycle();
        chk("release_edge6_d4", {k1[0], k0[0]}, 8'h00);
        repeat (10) cycle();
        hold(8'hFF, 14);

        // clean press on K02, then release
        hold(8'hFB, 14);
        chk("clean_press_d4", {k1[0], k0[0]}, 8'hFB);
        hold(8'hFF, 14);

        // bounce on K11: short pulse rejected, long pulse accepted
        hold(8'hDF, 3);
        hold(8'hFF, 4);
        chk("bounce_reject_d4", {k1[0], k0[0]}, 8'hFF);
        hold(8'hDF, 14);
        chk("bounce_accept_d4", {k1[0], k0[0]}, 8'hDF);
        hold(8'hFF, 14);

        // all eight lanes at once
        hold(8'h00, 14);
        hold(8'hFF, 14);

        // reset in the middle of a count on K00
        hold(8'hFE, 6);
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (9) cycle();
        chk("midcount_edge9_d8", {k1[1], k0[1]}, 8'hFF);
        cycle();
        chk("midcount_edge10_d8", {k1[1], k0[1]}, 8'hFE);
        hold(8'hFF, 14);

        // K13 toggling every 4 cycles
        for (int t = 0; t < 8; t++) hold(((t % 2) == 0) ? 8'h7F : 8'hFF, 4);
        hold(8'hFF, 14);

        // random slow changes with occasional resets
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) cycle();
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) raw = raw ^ 8'($urandom);
            cycle();
        end

        // random bouncing: fast flips on a random subset of lanes
        for (int n = 0; n < 400; n++) begin
            raw = raw ^ (8'($urandom) & 8'($urandom));
            cycle();
        end
        hold(8'hFF, 14);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Front end for the Tamagotchi button inputs.
- Synchronises the eight raw, asynchronous K0/K1 pin levels into the core clock domain and debounces each one.
- Feeds the clean levels to the input-lines edge/factor logic as input_k0 / input_k1.
- Guarantees that logic never sees metastable values or contact-bounce edges, so each physical press raises at most one interrupt factor.

Parameters:
- DEBOUNCE_CYCLES, 4096: consecutive clk cycles a synchronised level must differ from the current output before the output adopts it; legal range 1..65535.
- IDLE_LEVEL, 1: reset/idle value of every sync flop and output bit (buttons are pulled up, active-low).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- raw_k0  in  4  raw K00..K03 pin levels, asynchronous to clk
- raw_k1  in  4  raw K10..K13 pin levels, asynchronous to clk
- input_k0  out  4  debounced K0 levels
- input_k1  out  4  debounced K1 levels

Behaviour:
- Reset
  - Reset is asserted asynchronously and released synchronously to clk (internal release synchroniser).
  - While reset_n=0: all sync flops and outputs = {IDLE_LEVEL}; all counters = 0.
  - Reset mid-count discards the count; no output change results.
- Lanes: eight independent identical lanes (k0[3:0], k1[3:0]); no interaction between lanes.
- Sync stage: two flops per lane (s1 <= raw, s2 <= s1); s2 is the only value the debounce logic uses.
- Debounce, per lane:
  - Counter width is clog2(DEBOUNCE_CYCLES+1); it never wraps.
  - If s2 == output: counter <= 0.
  - If s2 != output and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s2 != output and counter == DEBOUNCE_CYCLES-1: output <= s2 and counter <= 0.
- Latency
  - A raw level that is stable before clk edge 1 and stays stable changes the output at edge 2+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=1, latency is 3 edges.
- Glitch rejection
  - Any return of s2 to the output value before the count completes clears the counter.
  - The output changes only after DEBOUNCE_CYCLES uninterrupted differing samples.
- Simultaneous events
  - Several lanes can complete in the same cycle; all of them update together.
  - Both directions (press and release) are filtered identically.
- Outputs are registered; there are no combinational paths from raw_* to any output.

Optional Feature:
- Macro: INPUT_DEBOUNCE_CHANGE_STROBE_EN.
- Defined
  - Adds output change_strobe [7:0]; bits [3:0] map to k0 and bits [7:4] to k1.
  - A bit pulses high for exactly one clk in the cycle its output bit is updated (coincident with the new output value). Reset value 0.
  - Used by save-state/activity tracking.
- Undefined
  - Port is absent and no strobe logic is generated.
  - All other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with raw=8'h00 -> input_k0=4'hF, input_k1=4'hF. After release, with raw held at 0 and DEBOUNCE_CYCLES=4 -> outputs go to 0 at edge 6 after release.
- Clean press (D=4): raw_k0[2] 1->0 before edge 1 -> input_k0 = 4'hF through edge 5, = 4'hB after edge 6; input_k1 unchanged.
- Bounce reject (D=4): raw_k1[1] low for 3 cycles, then high -> input_k1 stays 4'hF throughout. Then low for 4+ cycles -> input_k1 = 4'hD after 6 edges.
- Simultaneous: raw_k0=4'h0 and raw_k1=4'h0 on the same edge -> all eight outputs fall on the same edge. With the macro defined -> change_strobe = 8'hFF for one cycle.
- Reset mid-count (D=8): raw_k0[0]=0, assert reset_n at count 5 and release -> output stays at 1 until a full 2+8 edges after release.
- D=1: raw_k1[3] toggles every 4 cycles -> input_k1[3] follows, delayed by 3 edges; with the macro defined -> one strobe per toggle.
